rr_sel_sched16: RTL and testbench

//  Round-robin scheduler that shares one 16-way one-hot select path between 16 requesters.

---
 rtl/rr_sel_sched16.sv | 92 +++++++++
 tb/tb_rr_sel_sched16.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_sel_sched16.sv
// Round-robin scheduler that grants one of 16 requesters the shared one-hot select path.
// A grant is held until done or until the hold timeout, then a one-cycle release gap follows.
module rr_sel_sched16 #(
    parameter int HOLD_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic        done,
    output logic        grant_vld,
    output logic [3:0]  grant_idx,
    output logic [15:0] grant_onehot,
    output logic        timeout,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_t      state, state_d;
    logic [3:0]  ptr, ptr_d;
    logic [7:0]  hold_cnt, hold_d;
    logic [3:0]  idx_d;
    logic [3:0]  win;
    logic        vld_d, to_d, busy_d;
    logic [15:0] oh_d;

    // Scan downward in offset so the set bit nearest to ptr is the last one written.
    always_comb begin
        win = 4'd0;
        for (int k = 15; k >= 0; k--) begin
            if (req[ptr + 4'(k)]) win = ptr + 4'(k);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= 4'd0;
            hold_cnt     <= 8'd0;
            grant_idx    <= 4'd0;
            grant_vld    <= 1'b0;
            grant_onehot <= 16'h0000;
            timeout      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_d;
            ptr          <= ptr_d;
            hold_cnt     <= hold_d;
            grant_idx    <= idx_d;
            grant_vld    <= vld_d;
            grant_onehot <= oh_d;
            timeout      <= to_d;
            busy         <= busy_d;
        end
    end

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        hold_d  = hold_cnt;
        idx_d   = grant_idx;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    idx_d   = win;
                    hold_d  = 8'd0;
                end
            end
            GRANT: begin
                hold_d = hold_cnt + 8'd1;
                if (done || hold_cnt == HOLD_LAST) begin
                    state_d = RELEASE;
                    ptr_d   = grant_idx + 4'd1;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Done takes precedence over the hold limit, so the pulse needs !done.
    always_comb begin
        vld_d  = (state_d == GRANT);
        oh_d   = vld_d ? (16'h0001 << idx_d) : 16'h0000;
        to_d   = (state == GRANT) && !done && (hold_cnt == HOLD_LAST);
        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_rr_sel_sched16.sv
// Bench for rr_sel_sched16: vector table, directed corner sequences and a random run
// compared cycle by cycle against a behavioural model.
module tb_rr_sel_sched16;

    localparam int HOLD = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req = 16'h0000;
    logic        done = 1'b0;
    logic        grant_vld;
    logic [3:0]  grant_idx;
    logic [15:0] grant_onehot;
    logic        timeout;
    logic        busy;

    int checks = 0;
    int failures = 0;

    rr_sel_sched16 #(.HOLD_MAX(HOLD)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .grant_vld(grant_vld), .grant_idx(grant_idx), .grant_onehot(grant_onehot),
        .timeout(timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: mode 0 = waiting, 1 = owner holds the path, 2 = gap cycle
    int m_mode = 0;
    int m_owner = 0;
    int m_next = 0;
    int m_age = 0;
    bit m_to = 0;
    bit model_on = 1'b1;

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_step();
        m_to = 0;
        if (rst) begin
            m_mode = 0; m_owner = 0; m_next = 0; m_age = 0;
        end else if (m_mode == 0) begin
            if (req != 16'h0000) begin
                for (int off = 0; off < 16; off++) begin
                    if (req[(m_next + off) % 16]) begin
                        m_owner = (m_next + off) % 16;
                        break;
                    end
                end
                m_mode = 1;
                m_age = 1;
            end
        end else if (m_mode == 1) begin
            if (done || m_age == HOLD) begin
                m_to = !done;
                m_next = (m_owner + 1) % 16;
                m_mode = 2;
            end else begin
                m_age++;
            end
        end else begin
            m_mode = 0;
        end
    endtask

    task automatic model_cmp();
        chk("m_vld", {15'd0, grant_vld}, {15'd0, m_mode == 1});
        chk("m_onehot", grant_onehot, (m_mode == 1) ? (16'h0001 << m_owner) : 16'h0000);
        chk("m_timeout", {15'd0, timeout}, {15'd0, m_to});
        chk("m_busy", {15'd0, busy}, {15'd0, m_mode != 0});
        if (m_mode == 1) chk("m_idx", {12'd0, grant_idx}, 16'(m_owner));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        model_step();
        if (model_on) model_cmp();
    endtask

    task automatic wait_vld(input string nm);
        int n;
        n = 0;
        while (!grant_vld && n < 20) begin
            cyc();
            n++;
        end
        chk(nm, {15'd0, grant_vld}, 16'd1);
    endtask

    typedef struct {
        logic        rst;
        logic [15:0] req;
        logic        done;
        logic        vld;
        logic [3:0]  idx;
        logic [15:0] oh;
        logic        to;
        logic        busy;
    } vec_t;

    vec_t tv[10];

    initial begin
        int held;
        // reset with all requesting, first grant 0, then single request to 5
        tv[0] = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0};
        tv[1] = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0};
        tv[2] = '{1'b0, 16'hFFFF, 1'b0, 1'b1, 4'd0, 16'h0001, 1'b0, 1'b1};
        tv[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1};
        tv[4] = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0};
        tv[5] = '{1'b0, 16'h0020, 1'b0, 1'b1, 4'd5, 16'h0020, 1'b0, 1'b1};
        tv[6] = '{1'b0, 16'h0000, 1'b0, 1'b1, 4'd5, 16'h0020, 1'b0, 1'b1};
        tv[7] = '{1'b0, 16'h0000, 1'b0, 1'b1, 4'd5, 16'h0020, 1'b0, 1'b1};
        tv[8] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd5, 16'h0000, 1'b0, 1'b1};
        tv[9] = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd5, 16'h0000, 1'b0, 1'b0};

        model_on = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rst = tv[i].rst; req = tv[i].req; done = tv[i].done;
            cyc();
            chk($sformatf("tv%0d_vld", i), {15'd0, grant_vld}, {15'd0, tv[i].vld});
            chk($sformatf("tv%0d_oh", i), grant_onehot, tv[i].oh);
            chk($sformatf("tv%0d_to", i), {15'd0, timeout}, {15'd0, tv[i].to});
            chk($sformatf("tv%0d_busy", i), {15'd0, busy}, {15'd0, tv[i].busy});
            if (tv[i].vld || tv[i].rst)
                chk($sformatf("tv%0d_idx", i), {12'd0, grant_idx}, {12'd0, tv[i].idx});
        end
        model_on = 1'b1;

        // round robin under full request
        rst = 1'b1; req = 16'hFFFF; done = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        for (int g = 0; g < 17; g++) begin
            wait_vld("rr_wait");
            chk("rr_idx", {12'd0, grant_idx}, 16'(g % 16));
            chk("rr_oh", grant_onehot, 16'h0001 << (g % 16));
            cyc();
            done = 1'b1;
            cyc();
            done = 1'b0;
        end

        // wrap 15 -> 0
        req = 16'h0000; cyc(); cyc();
        req = 16'h4000;
        wait_vld("wrap_w14");
        chk("wrap_idx14", {12'd0, grant_idx}, 16'd14);
        req = 16'h8001; done = 1'b1; cyc(); done = 1'b0;
        wait_vld("wrap_w15");
        chk("wrap_idx15", {12'd0, grant_idx}, 16'd15);
        done = 1'b1; cyc(); done = 1'b0;
        wait_vld("wrap_w0");
        chk("wrap_idx0", {12'd0, grant_idx}, 16'd0);
        req = 16'h0000; done = 1'b1; cyc(); done = 1'b0; cyc();

        // hold timeout, owner drops req mid-grant
        req = 16'h0100;
        wait_vld("to_wait");
        chk("to_idx", {12'd0, grant_idx}, 16'd8);
        req = 16'h0000;
        held = 1;
        while (held < 20) begin
            cyc();
            if (!grant_vld) break;
            held++;
        end
        chk("to_len", 16'(held), 16'(HOLD));
        chk("to_pulse", {15'd0, timeout}, 16'd1);
        cyc();
        chk("to_pulse_end", {15'd0, timeout}, 16'd0);

        // done on the final hold cycle suppresses the timeout
        req = 16'h0100;
        wait_vld("td_wait");
        req = 16'h0000;
        for (int i = 0; i < HOLD - 1; i++) cyc();
        chk("td_still", {15'd0, grant_vld}, 16'd1);
        done = 1'b1; cyc(); done = 1'b0;
        chk("td_vld", {15'd0, grant_vld}, 16'd0);
        chk("td_noto", {15'd0, timeout}, 16'd0);
        cyc();

        // reset in the middle of a grant
        req = 16'h0008;
        wait_vld("mr_wait");
        chk("mr_idx3", {12'd0, grant_idx}, 16'd3);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("mr_vld", {15'd0, grant_vld}, 16'd0);
        chk("mr_busy", {15'd0, busy}, 16'd0);
        chk("mr_oh", grant_onehot, 16'h0000);
        req = 16'h0009;
        wait_vld("mr_w0");
        chk("mr_idx0", {12'd0, grant_idx}, 16'd0);
        done = 1'b1; cyc(); done = 1'b0;
        wait_vld("mr_w3");
        chk("mr_idx3b", {12'd0, grant_idx}, 16'd3);
        done = 1'b1; cyc(); done = 1'b0;

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst  = ($urandom_range(0, 99) == 0);
            req  = ($urandom_range(0, 2) == 0) ? 16'($urandom) : (16'h0001 << $urandom_range(0, 15)) & 16'($urandom);
            done = ($urandom_range(0, 5) == 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
